instr_exec_unit: RTL and testbench
==================================

Name: instr_exec_unit

Overview:
- Downstream consumer of the instruction fetch unit: accepts 4-bit instruction codes, decodes them and executes them on a 4-entry register file.
- Single-cycle ops: INC, ADD, SHL. Multi-cycle op: MUL, shift-add, DATA_W cycles.
- Drives Stall back to the fetch unit so it holds its current code while a MUL is in progress.

Parameters:
- DATA_W, 8, register, ALU and multiplier width (min 2).

Ports:
- CLOCK  input  1  single system clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- Instruction_Code  input  4  [3:2] opcode, [1:0] register index r.
- Instr_Valid  input  1  Instruction_Code is valid this cycle.
- Stall  output  1  high: code not accepted; fetch must hold.
- Retire  output  1  one-cycle pulse on each completed writeback.
- Zero_Flag  output  1  result of last retired instruction == 0.
- Carry_Flag  output  1  carry/overflow of last retired instruction.
- Dbg_Sel  input  2  register-file debug read select.
- Dbg_Data  output  DATA_W  combinational read of R[Dbg_Sel].
- Retire_Count  output  16  retired-instruction count (see Optional Feature).

Behaviour:
Opcodes:
- 00 INC: R[r] <= R[r]+1. Carry = carry-out.
- 01 ADD: R0 <= R0+R[r]. Carry = carry-out.
- 10 SHL: R[r] <= R[r]<<1. Carry = old MSB.
- 11 MUL: R0 <= low DATA_W bits of R0*R[r]. Carry = 1 if any high product bit is nonzero.

Arithmetic: all results are truncated to DATA_W and wrap modulo 2^DATA_W.

Reset (RESET=0, async):
- R0..R3=0, D-register valid=0, FSM=RUN.
- Stall=0, Retire=0, Zero_Flag=0, Carry_Flag=0, Retire_Count=0.
- Takes effect immediately, including mid-MUL; the partial product is discarded.

Accept:
- Code is latched into the D register on a rising edge when Instr_Valid=1 and Stall=0.
- Instr_Valid=0 at that edge leaves D invalid (bubble).

Execute, single-cycle ops:
- Executed from D at the next edge; operands are read from the register file at that time.
- Writeback, flags and a Retire pulse occur at that edge.
- Latency: code presented at edge N is visible on Dbg_Data after edge N+1.
- Back-to-back dependent ops are correct without forwarding or bubbles.

FSM states: RUN, MUL_BUSY.
- RUN with D holding MUL: at the next edge, capture multiplicand R0 and multiplier R[r]; go to MUL_BUSY with bit counter = 0.
- MUL_BUSY: one shift-add step per cycle, DATA_W steps.
- After the final step: write R0, update flags, pulse Retire, clear D valid, return to RUN.
- MUL occupies D for 1+DATA_W cycles.

Stall:
- Stall = D valid AND D opcode == MUL.
- Combinational from registers; no dependence on Instr_Valid.
- A code presented while Stall=1 is ignored; fetch re-presents it.
- The code following a MUL is accepted at the edge where the MUL retires.

Flags:
- Updated only on retire; hold between retires.
- Zero_Flag = (written result == 0).

Register index r=0:
- INC/SHL operate on R0.
- ADD doubles R0.
- MUL squares R0.

Dbg_Data: pure combinational read of current register contents; no side effects.

Optional Feature:
Macro: IEU_RETIRE_COUNT_EN.
- Defined: Retire_Count is a 16-bit counter, incremented on each Retire pulse. It wraps from 0xFFFF to 0x0000 and is cleared by RESET.
- Undefined: the counter logic is not built and Retire_Count is tied to 16'h0000. The port is always present.

Test Plan:
- Reset check: hold RESET=0 with Instr_Valid=1 and codes toggling -> all Dbg_Data reads 0x00; Stall=0, Retire=0, flags=0.
- Back-to-back INC: 0x1 presented for 3 consecutive cycles, then 0x5 (ADD R1) -> R1=0x03 and R0=0x03; 4 Retire pulses on consecutive cycles; Zero_Flag=0, Carry_Flag=0.
- Wrap: INC R1 at R1=0xFF -> R1=0x00, Carry_Flag=1, Zero_Flag=1. Next, SHL R3 with R3=0x80 (0xB) -> R3=0x00, Carry_Flag=1.
- MUL with hold: R0=0x03, R2=0x05; present 0xE then hold 0x1 -> Stall high 9 consecutive cycles; R0=0x0F on Retire, Carry_Flag=0; the INC R1 is accepted exactly once, at the MUL retire edge.
- MUL overflow: R0=0x10 * R1=0x10 (0xD) -> R0=0x00, Carry_Flag=1, Zero_Flag=1.
- Reset mid-MUL: drop RESET during MUL_BUSY step 4 -> Stall=0 and R0=0x00 immediately, with no Retire pulse. After release, INC R0 -> R0=0x01. With IEU_RETIRE_COUNT_EN, Retire_Count=1.

Source files
------------

// File: rtl/instr_exec_unit.sv
// instr_exec_unit: decode/execute stage fed by the instruction fetch unit.
// Executes 4-bit codes ([3:2] opcode, [1:0] register index) on a 4-entry
// register file. INC/ADD/SHL finish in one cycle. MUL is a shift-add
// multiplier that takes DATA_W steps, and Stall holds fetch while it runs.
// Optional build macro IEU_RETIRE_COUNT_EN adds a 16-bit retired-instruction
// counter. Without it, Retire_Count is tied to zero.
module instr_exec_unit #(
   parameter int DATA_W = 8
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic [3:0]        Instruction_Code,
   input  logic              Instr_Valid,
   output logic              Stall,
   output logic              Retire,
   output logic              Zero_Flag,
   output logic              Carry_Flag,
   input  logic [1:0]        Dbg_Sel,
   output logic [DATA_W-1:0] Dbg_Data,
   output logic [15:0]       Retire_Count
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   localparam logic [1:0] OP_INC = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SHL = 2'b10;
   localparam logic [1:0] OP_MUL = 2'b11;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MUL_BUSY = 1'b1
   } state_t;

   // Architectural state
   logic [DATA_W-1:0]   rf_q [4];
   logic                d_valid_q;
   logic [3:0]          d_code_q;
   state_t              state_q;
   logic                retire_q;
   logic                zero_q;
   logic                carry_q;

   // Multiplier working registers
   logic [2*DATA_W-1:0] mcand_q;
   logic [DATA_W-1:0]   mplier_q;
   logic [2*DATA_W-1:0] acc_q;
   logic [CNT_W-1:0]    cnt_q;

   // Decode of the D register
   logic [1:0]          d_op;
   logic [1:0]          d_r;
   logic                stall_w;
   logic                mul_last;
   logic                mul_start;
   logic                exec_single;
   logic                accept;
   logic                retire_d;

   // Single-cycle ALU results
   logic [DATA_W-1:0]   opnd;
   logic [DATA_W:0]     sum_ext;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_carry;
   logic [1:0]          wr_idx;

   // One shift-add step of the multiplier
   logic [2*DATA_W-1:0] acc_step;
   logic [DATA_W-1:0]   mul_res;
   logic                mul_carry;

   // Decode and handshake. The final MUL step frees D, so the code that fetch
   // has been holding is accepted at that same edge.
   always_comb begin
      d_op        = d_code_q[3:2];
      d_r         = d_code_q[1:0];
      stall_w     = d_valid_q && (d_op == OP_MUL);
      mul_last    = (state_q == ST_MUL_BUSY) && (cnt_q == CNT_W'(DATA_W - 1));
      mul_start   = (state_q == ST_RUN) && stall_w;
      exec_single = (state_q == ST_RUN) && d_valid_q && (d_op != OP_MUL);
      accept      = Instr_Valid && (!stall_w || mul_last);
      retire_d    = exec_single || mul_last;
   end

   // Single-cycle ALU. Operands are read from the register file as it stands
   // at the execute edge, so dependent back-to-back ops need no forwarding.
   always_comb begin
      opnd      = rf_q[d_r];
      sum_ext   = '0;
      alu_res   = '0;
      alu_carry = 1'b0;
      wr_idx    = d_r;
      case (d_op)
         OP_INC: begin
            sum_ext   = {1'b0, opnd} + (DATA_W + 1)'(1);
            alu_res   = sum_ext[DATA_W-1:0];
            alu_carry = sum_ext[DATA_W];
         end
         OP_ADD: begin
            sum_ext   = {1'b0, rf_q[0]} + {1'b0, opnd};
            alu_res   = sum_ext[DATA_W-1:0];
            alu_carry = sum_ext[DATA_W];
            wr_idx    = 2'd0;
         end
         OP_SHL: begin
            alu_res   = {opnd[DATA_W-2:0], 1'b0};
            alu_carry = opnd[DATA_W-1];
         end
         default: begin
            alu_res   = '0;
            alu_carry = 1'b0;
         end
      endcase
   end

   // Multiplier step: add the shifted multiplicand when the current multiplier bit is set
   always_comb begin
      acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      mul_res   = acc_step[DATA_W-1:0];
      mul_carry = |acc_step[2*DATA_W-1:DATA_W];
   end

   // Main sequential block: D register, RUN/MUL_BUSY FSM, writeback and flags
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < 4; i++) begin
            rf_q[i] <= '0;
         end
         d_valid_q <= 1'b0;
         d_code_q  <= '0;
         state_q   <= ST_RUN;
         retire_q  <= 1'b0;
         zero_q    <= 1'b0;
         carry_q   <= 1'b0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
      end else begin
         retire_q <= 1'b0;

         // D register: load on accept. Otherwise it goes empty once its
         // instruction has left (a bubble). It holds while a MUL is in flight.
         if (accept) begin
            d_valid_q <= 1'b1;
            d_code_q  <= Instruction_Code;
         end else if (!stall_w || mul_last) begin
            d_valid_q <= 1'b0;
         end

         case (state_q)
            ST_RUN: begin
               if (exec_single) begin
                  rf_q[wr_idx] <= alu_res;
                  zero_q       <= (alu_res == '0);
                  carry_q      <= alu_carry;
                  retire_q     <= 1'b1;
               end else if (mul_start) begin
                  mcand_q  <= {{DATA_W{1'b0}}, rf_q[0]};
                  mplier_q <= rf_q[d_r];
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  state_q  <= ST_MUL_BUSY;
               end
            end
            ST_MUL_BUSY: begin
               acc_q    <= acc_step;
               mcand_q  <= {mcand_q[2*DATA_W-2:0], 1'b0};
               mplier_q <= {1'b0, mplier_q[DATA_W-1:1]};
               cnt_q    <= cnt_q + CNT_W'(1);
               if (mul_last) begin
                  rf_q[0]  <= mul_res;
                  zero_q   <= (mul_res == '0);
                  carry_q  <= mul_carry;
                  retire_q <= 1'b1;
                  state_q  <= ST_RUN;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

`ifdef IEU_RETIRE_COUNT_EN
   logic [15:0] retire_cnt_q;

   // Retired-instruction counter. It advances at the edge that raises Retire and wraps naturally.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         retire_cnt_q <= 16'h0000;
      end else if (retire_d) begin
         retire_cnt_q <= retire_cnt_q + 16'h0001;
      end
   end

   assign Retire_Count = retire_cnt_q;
`else
   assign Retire_Count = 16'h0000;
`endif

   assign Stall      = stall_w;
   assign Retire     = retire_q;
   assign Zero_Flag  = zero_q;
   assign Carry_Flag = carry_q;
   assign Dbg_Data   = rf_q[Dbg_Sel];

endmodule

// File: tb/tb_instr_exec_unit.sv
// Scoreboard bench for instr_exec_unit. Stimulus pushes the hand-computed
// writeback for every issued code. A monitor pops an entry on each Retire
// pulse and checks the register, flags and (when built) the retire counter.
module tb_instr_exec_unit;

   logic        CLOCK;
   logic        RESET;
   logic [3:0]  Instruction_Code;
   logic        Instr_Valid;
   logic        Stall;
   logic        Retire;
   logic        Zero_Flag;
   logic        Carry_Flag;
   logic [1:0]  Dbg_Sel;
   logic [7:0]  Dbg_Data;
   logic [15:0] Retire_Count;

   typedef struct {
      logic [1:0] idx;
      logic [7:0] val;
      logic       z;
      logic       c;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   exp_cnt  = 0;

   instr_exec_unit #(.DATA_W(8)) dut (
      .CLOCK            (CLOCK),
      .RESET            (RESET),
      .Instruction_Code (Instruction_Code),
      .Instr_Valid      (Instr_Valid),
      .Stall            (Stall),
      .Retire           (Retire),
      .Zero_Flag        (Zero_Flag),
      .Carry_Flag       (Carry_Flag),
      .Dbg_Sel          (Dbg_Sel),
      .Dbg_Data         (Dbg_Data),
      .Retire_Count     (Retire_Count)
   );

   initial begin
      CLOCK = 1'b0;
      forever #5 CLOCK = ~CLOCK;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end else begin
         $display("ok   %s = 0x%0h", name, act);
      end
   endtask

   // Present a code for one accepting edge and record the writeback it must produce
   task automatic issue(input logic [3:0] code, input logic [1:0] idx,
                        input logic [7:0] val, input logic z, input logic c);
      exp_t e;
      e.idx = idx; e.val = val; e.z = z; e.c = c;
      sb_q.push_back(e);
      Instr_Valid      = 1'b1;
      Instruction_Code = code;
      @(posedge CLOCK); #1;
   endtask

   task automatic idle(input int n);
      Instr_Valid = 1'b0;
      repeat (n) begin
         @(posedge CLOCK); #1;
      end
   endtask

   // Monitor: each Retire pulse must match the oldest expected writeback
   initial begin
      exp_t e;
      forever begin
         @(negedge CLOCK);
         if (!RESET) begin
            exp_cnt = 0;
         end else if (Retire) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_retire: got Retire=1, expected no retire (t=%0t)", $time);
            end else begin
               e = sb_q.pop_front();
               exp_cnt++;
               Dbg_Sel = e.idx;
               #1;
               chk($sformatf("retire R%0d", e.idx), 32'(Dbg_Data), 32'(e.val));
               chk("retire Zero_Flag", 32'(Zero_Flag), 32'(e.z));
               chk("retire Carry_Flag", 32'(Carry_Flag), 32'(e.c));
`ifdef IEU_RETIRE_COUNT_EN
               chk("Retire_Count", 32'(Retire_Count), 32'(exp_cnt));
`endif
            end
         end
      end
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RESET            = 1'b0;
      Instr_Valid      = 1'b1;
      Instruction_Code = 4'hE;
      Dbg_Sel          = 2'd0;

      // Reset held while valid codes toggle: nothing may execute
      for (int k = 0; k < 4; k++) begin
         Instruction_Code = (k % 2 == 0) ? 4'hE : 4'h1;
         @(posedge CLOCK); #1;
         chk("reset Stall", 32'(Stall), 32'd0);
         chk("reset Retire", 32'(Retire), 32'd0);
      end
      for (int s = 0; s < 4; s++) begin
         Dbg_Sel = 2'(s);
         #1;
         chk($sformatf("reset R%0d", s), 32'(Dbg_Data), 32'h00);
      end
      chk("reset Zero_Flag", 32'(Zero_Flag), 32'd0);
      chk("reset Carry_Flag", 32'(Carry_Flag), 32'd0);
      chk("reset Retire_Count", 32'(Retire_Count), 32'd0);
      Instr_Valid = 1'b0;
      RESET = 1'b1;
      @(posedge CLOCK); #1;

      // Back-to-back dependent INC R1 x3, then ADD R1
      issue(4'h1, 2'd1, 8'h01, 1'b0, 1'b0);
      issue(4'h1, 2'd1, 8'h02, 1'b0, 1'b0);
      issue(4'h1, 2'd1, 8'h03, 1'b0, 1'b0);
      issue(4'h5, 2'd0, 8'h03, 1'b0, 1'b0);

      // Walk R1 up to 0xFF, then wrap it
      for (int i = 4; i < 256; i++) begin
         issue(4'h1, 2'd1, 8'(i), 1'b0, 1'b0);
      end
      issue(4'h1, 2'd1, 8'h00, 1'b1, 1'b1);

      // R3 = 1, shift up to 0x80, then shift out the MSB
      issue(4'h3, 2'd3, 8'h01, 1'b0, 1'b0);
      for (int i = 1; i < 8; i++) begin
         issue(4'hB, 2'd3, 8'(1 << i), 1'b0, 1'b0);
      end
      issue(4'hB, 2'd3, 8'h00, 1'b1, 1'b1);

      // R2 = 5 (R0 already 3), then MUL R2 while fetch holds INC R1
      for (int i = 1; i <= 5; i++) begin
         issue(4'h2, 2'd2, 8'(i), 1'b0, 1'b0);
      end
      issue(4'hE, 2'd0, 8'h0F, 1'b0, 1'b0);
      sb_q.push_back('{idx: 2'd1, val: 8'h01, z: 1'b0, c: 1'b0});
      for (int k = 0; k < 9; k++) begin
         Instr_Valid      = 1'b1;
         Instruction_Code = 4'h1;
         chk($sformatf("mul Stall cycle %0d", k), 32'(Stall), 32'd1);
         @(posedge CLOCK); #1;
      end
      Instr_Valid = 1'b0;
      chk("Stall after mul retire", 32'(Stall), 32'd0);
      idle(3);

      // MUL overflow: R0=0x10, R1=0x10
      issue(4'h0, 2'd0, 8'h10, 1'b0, 1'b0);
      issue(4'h9, 2'd1, 8'h02, 1'b0, 1'b0);
      issue(4'h9, 2'd1, 8'h04, 1'b0, 1'b0);
      issue(4'h9, 2'd1, 8'h08, 1'b0, 1'b0);
      issue(4'h9, 2'd1, 8'h10, 1'b0, 1'b0);
      issue(4'hD, 2'd0, 8'h00, 1'b1, 1'b1);
      idle(12);

      // Reset in the middle of a MUL: partial product is discarded, no retire
      issue(4'h0, 2'd0, 8'h01, 1'b0, 1'b0);
      idle(2);
      Instr_Valid      = 1'b1;
      Instruction_Code = 4'hD;
      @(posedge CLOCK); #1;
      Instr_Valid = 1'b0;
      chk("mid-mul Stall before reset", 32'(Stall), 32'd1);
      repeat (4) begin
         @(posedge CLOCK); #1;
      end
      RESET = 1'b0;
      #1;
      Dbg_Sel = 2'd0;
      #1;
      chk("mid-mul reset Stall", 32'(Stall), 32'd0);
      chk("mid-mul reset Retire", 32'(Retire), 32'd0);
      chk("mid-mul reset R0", 32'(Dbg_Data), 32'h00);
      @(posedge CLOCK); #1;
      chk("mid-mul reset held Retire", 32'(Retire), 32'd0);
      RESET = 1'b1;
      @(posedge CLOCK); #1;
      issue(4'h0, 2'd0, 8'h01, 1'b0, 1'b0);
      idle(5);

      chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
